// File: rtl/mobile_storage_clk_gen.sv
// Multi-card card-clock generator: one shared programmable period counter feeds
// per-card gated cclk levels plus cycle-aligned drive and sample strobes.
module mobile_storage_clk_gen #(
  parameter int               NUM_CARDS     = 2,
  parameter int               DIV_W         = 8,
  parameter int               PH_W          = DIV_W + 1,
  parameter logic [DIV_W-1:0] RESET_DIV     = 8'd49,
  parameter int               READY_PERIODS = 4
) (
  input  logic                 clk_2x,
  input  logic                 reset_n,
  input  logic [NUM_CARDS-1:0] clk_enable,
  input  logic [NUM_CARDS-1:0] clk_lp_en,
  input  logic [NUM_CARDS-1:0] card_busy,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic [PH_W-1:0]      drv_phase,
  input  logic [PH_W-1:0]      smpl_phase,
  input  logic                 cfg_update,
  output logic                 cfg_ack,
  output logic                 clk_ready,
  output logic [NUM_CARDS-1:0] cclk_out,
  output logic [NUM_CARDS-1:0] cclk_drv_stb,
  output logic [NUM_CARDS-1:0] cclk_smpl_stb,
  output logic                 rdy_state_dbg
);

  localparam int TALLY_W = $clog2(READY_PERIODS + 1);

  typedef enum logic {ST_WAIT = 1'b0, ST_READY = 1'b1} rdy_state_e;

  logic [PH_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d, sh_div_q, sh_div_d;
  logic [PH_W-1:0]      drv_q, drv_d, sh_drv_q, sh_drv_d;
  logic [PH_W-1:0]      smpl_q, smpl_d, sh_smpl_q, sh_smpl_d;
  logic                 pend_q, pend_d;
  logic [NUM_CARDS-1:0] run_q, run_d;
  rdy_state_e           state_q, state_d;
  logic [TALLY_W-1:0]   tally_q, tally_d;
  logic                 ack_q, ack_d;
  logic [NUM_CARDS-1:0] cclk_q, cclk_d;
  logic [NUM_CARDS-1:0] drv_stb_q, drv_stb_d;
  logic [NUM_CARDS-1:0] smpl_stb_q, smpl_stb_d;

  logic [PH_W-1:0] last_q, last_d, drv_pos, smpl_pos;
  logic            wrap, apply;

  // Handshake: cfg_update is a single-cycle request with no back-pressure; it
  // may repeat freely (the shadow simply takes the newest values). cfg_ack
  // pulses for one cycle in the last cycle of the old period, the cycle at
  // whose end the shadow becomes active.
  always_comb begin
    last_q = {div_q, 1'b1};
    wrap   = (cnt_q == last_q);
    apply  = wrap & pend_q;

    cnt_d     = wrap ? '0 : cnt_q + PH_W'(1);
    div_d     = div_q;
    drv_d     = drv_q;
    smpl_d    = smpl_q;
    sh_div_d  = sh_div_q;
    sh_drv_d  = sh_drv_q;
    sh_smpl_d = sh_smpl_q;
    pend_d    = pend_q;
    run_d     = run_q;

    if (apply) begin
      div_d  = sh_div_q;
      drv_d  = sh_drv_q;
      smpl_d = sh_smpl_q;
      pend_d = 1'b0;
    end
    // Start/stop only at the period boundary so no runt phase is ever emitted.
    if (wrap) begin
      run_d = clk_enable & ~(clk_lp_en & ~card_busy);
    end
    if (cfg_update) begin
      sh_div_d  = clk_div;
      sh_drv_d  = drv_phase;
      sh_smpl_d = smpl_phase;
      pend_d    = 1'b1;
    end

    // Outputs are registered from next-state so they line up with cnt_q.
    last_d     = {div_d, 1'b1};
    drv_pos    = (drv_d > last_d) ? last_d : drv_d;
    smpl_pos   = (smpl_d > last_d) ? last_d : smpl_d;
    cclk_d     = run_d & {NUM_CARDS{cnt_d <= {1'b0, div_d}}};
    drv_stb_d  = run_d & {NUM_CARDS{cnt_d == drv_pos}};
    smpl_stb_d = run_d & {NUM_CARDS{cnt_d == smpl_pos}};
    ack_d      = pend_d & (cnt_d == last_d);
  end

  always_comb begin
    state_d = state_q;
    tally_d = tally_q;
    if (cfg_update) begin
      state_d = ST_WAIT;
      tally_d = '0;
    end else if (apply) begin
      tally_d = '0;
    end else if (wrap && state_q == ST_WAIT) begin
      if (tally_q == TALLY_W'(READY_PERIODS - 1)) begin
        state_d = ST_READY;
        tally_d = '0;
      end else begin
        tally_d = tally_q + TALLY_W'(1);
      end
    end
  end

  always_ff @(posedge clk_2x or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      div_q      <= RESET_DIV;
      drv_q      <= '0;
      smpl_q     <= '0;
      sh_div_q   <= RESET_DIV;
      sh_drv_q   <= '0;
      sh_smpl_q  <= '0;
      pend_q     <= 1'b0;
      run_q      <= '0;
      state_q    <= ST_WAIT;
      tally_q    <= '0;
      ack_q      <= 1'b0;
      cclk_q     <= '0;
      drv_stb_q  <= '0;
      smpl_stb_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      drv_q      <= drv_d;
      smpl_q     <= smpl_d;
      sh_div_q   <= sh_div_d;
      sh_drv_q   <= sh_drv_d;
      sh_smpl_q  <= sh_smpl_d;
      pend_q     <= pend_d;
      run_q      <= run_d;
      state_q    <= state_d;
      tally_q    <= tally_d;
      ack_q      <= ack_d;
      cclk_q     <= cclk_d;
      drv_stb_q  <= drv_stb_d;
      smpl_stb_q <= smpl_stb_d;
    end
  end

  assign cfg_ack       = ack_q;
  assign clk_ready     = (state_q == ST_READY);
  assign cclk_out      = cclk_q;
  assign cclk_drv_stb  = drv_stb_q;
  assign cclk_smpl_stb = smpl_stb_q;
  assign rdy_state_dbg = state_q;

endmodule

// File: tb/tb_mobile_storage_clk_gen.sv
// Bench for mobile_storage_clk_gen: period-level reference model with an
// expected-output queue, directed corner sequences and a strobe table.
module tb_mobile_storage_clk_gen;
  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int PW  = 9;
  localparam int EW  = 3 * NC + 2;
  localparam int RP  = 4;
  localparam int INF = 32'h7fff_ffff;

  logic          clk_2x = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC-1:0] clk_enable, clk_lp_en, card_busy;
  logic [DW-1:0] clk_div;
  logic [PW-1:0] drv_phase, smpl_phase;
  logic          cfg_update;
  logic          cfg_ack, clk_ready, rdy_state_dbg;
  logic [NC-1:0] cclk_out, cclk_drv_stb, cclk_smpl_stb;

  mobile_storage_clk_gen #(.NUM_CARDS(NC), .DIV_W(DW), .PH_W(PW)) dut (
    .clk_2x(clk_2x), .reset_n(reset_n), .clk_enable(clk_enable),
    .clk_lp_en(clk_lp_en), .card_busy(card_busy), .clk_div(clk_div),
    .drv_phase(drv_phase), .smpl_phase(smpl_phase), .cfg_update(cfg_update),
    .cfg_ack(cfg_ack), .clk_ready(clk_ready), .cclk_out(cclk_out),
    .cclk_drv_stb(cclk_drv_stb), .cclk_smpl_stb(cclk_smpl_stb),
    .rdy_state_dbg(rdy_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_2x = ~clk_2x;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Time is the cycle index since reset release; a period is a window
  // [m_start, m_start + 2*div + 2) and each card's run flag is fixed per window.
  int m_t, m_start, m_div, m_drv, m_smpl, m_sh_div, m_sh_drv, m_sh_smpl, m_ready_at;
  bit m_pend;
  bit [NC-1:0] m_run;

  function automatic void model_reset();
    m_t = 0; m_start = 0; m_div = 49; m_drv = 0; m_smpl = 0;
    m_sh_div = 49; m_sh_drv = 0; m_sh_smpl = 0; m_pend = 0; m_run = '0;
    m_ready_at = RP * (2 * 49 + 2);
    exp_q.delete();
  endfunction

  function automatic logic [EW-1:0] exp_now();
    int last, pos, dp, sp;
    logic [NC-1:0] c, d, s;
    logic a, r;
    last = 2 * m_div + 1;
    pos  = m_t - m_start;
    dp   = (m_drv > last) ? last : m_drv;
    sp   = (m_smpl > last) ? last : m_smpl;
    for (int i = 0; i < NC; i++) begin
      c[i] = m_run[i] && (pos <= m_div);
      d[i] = m_run[i] && (pos == dp);
      s[i] = m_run[i] && (pos == sp);
    end
    a = m_pend && (pos == last);
    r = (m_t >= m_ready_at);
    return {a, r, c, d, s};
  endfunction

  function automatic void model_step();
    if (m_t - m_start == 2 * m_div + 1) begin
      if (m_pend) begin
        m_div = m_sh_div; m_drv = m_sh_drv; m_smpl = m_sh_smpl; m_pend = 0;
        m_ready_at = m_t + 1 + RP * (2 * m_div + 2);
      end
      m_start = m_t + 1;
      for (int i = 0; i < NC; i++)
        m_run[i] = clk_enable[i] && !(clk_lp_en[i] && !card_busy[i]);
    end
    if (cfg_update) begin
      m_sh_div = clk_div; m_sh_drv = drv_phase; m_sh_smpl = smpl_phase;
      m_pend = 1; m_ready_at = INF;
    end
    m_t++;
    exp_q.push_back(exp_now());
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic sb_check();
    logic [EW-1:0] act, exp;
    act = {cfg_ack, clk_ready, cclk_out, cclk_drv_stb, cclk_smpl_stb};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL cyc: expected queue empty at cycle %0d", m_t);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL cyc %0d: got %b expected %b (ack,rdy,cclk,drv,smpl)", m_t, act, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_2x);
    model_step();
    #1;
    sb_check();
  endtask

  task automatic apply_cfg(input int div, input int drv, input int smpl);
    int n;
    clk_div = DW'(div); drv_phase = PW'(drv); smpl_phase = PW'(smpl);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    n = 1;
    while (!cfg_ack && n < 600) begin
      tick();
      n++;
    end
    check("cfg_ack_seen", cfg_ack, 1);
  endtask

  // ---------------- strobe table ----------------
  typedef struct {
    int div; int drv; int smpl; int exp_drv; int exp_smpl; int exp_high;
  } vec_t;
  vec_t vecs[7];

  logic [NC-1:0] all_outs_zero;
  int hl, n, lat, dcnt, scnt, dpos, spos, highs, b;
  int runs[$];
  bit prev;
  logic s_q[$];

  initial begin
    vecs[0] = '{2, 9, 3, 5, 3, 3};
    vecs[1] = '{1, 0, 2, 0, 2, 2};
    vecs[2] = '{0, 0, 1, 0, 1, 1};
    vecs[3] = '{0, 5, 7, 1, 1, 1};
    vecs[4] = '{3, 7, 8, 7, 7, 4};
    vecs[5] = '{4, 2, 9, 2, 9, 5};
    vecs[6] = '{6, 13, 20, 13, 13, 7};

    clk_enable = '0; clk_lp_en = '0; card_busy = '0;
    clk_div = '0; drv_phase = '0; smpl_phase = '0; cfg_update = 1'b0;

    // Reset and defaults: nothing runs, ready after 4 periods of 100 cycles.
    repeat (3) @(posedge clk_2x);
    #3;
    check("reset_outs", {cfg_ack, clk_ready, cclk_out, cclk_drv_stb, cclk_smpl_stb}, 0);
    @(negedge clk_2x);
    reset_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 402; k++) begin
      tick();
      if (k == 399) check("ready_early", clk_ready, 0);
      if (k == 400) check("ready_400", clk_ready, 1);
    end

    // div=1, drv=0, smpl=2 on card 0.
    clk_enable[0] = 1'b1;
    apply_cfg(1, 0, 2);
    for (int j = 0; j < 8; j++) begin
      tick();
      check("div1_pat", {cclk_out[1], cclk_out[0], cclk_drv_stb[0], cclk_smpl_stb[0]},
            {1'b0, (j % 4) < 2, (j % 4) == 0, (j % 4) == 2});
    end

    // Switch to div=3 at cnt=1: ack two cycles later, no runt high phase.
    s_q.delete();
    n = 0;
    while (!(m_t - m_start == 1 && m_div == 1) && n < 20) begin
      tick(); s_q.push_back(cclk_out[0]); n++;
    end
    clk_div = 8'd3; drv_phase = 9'd1; smpl_phase = 9'd5; cfg_update = 1'b1;
    tick(); s_q.push_back(cclk_out[0]);
    cfg_update = 1'b0;
    check("ack_lat_1", cfg_ack, 0);
    tick(); s_q.push_back(cclk_out[0]);
    check("ack_lat_2", cfg_ack, 1);
    repeat (14) begin tick(); s_q.push_back(cclk_out[0]); end
    runs.delete(); hl = 0;
    foreach (s_q[i]) begin
      if (s_q[i]) hl++;
      else if (hl != 0) begin runs.push_back(hl); hl = 0; end
    end
    check("run_cnt", runs.size(), 3);
    if (runs.size() >= 3) begin
      check("high_run0", runs[0], 2);
      check("high_run1", runs[1], 4);
      check("high_run2", runs[2], 4);
    end

    // Low-power stop and restart on card 1 (div=3, period 8).
    clk_enable[1] = 1'b1; clk_lp_en[1] = 1'b1; card_busy[1] = 1'b1;
    n = 0;
    while (!(m_run[1] && m_t - m_start == 1) && n < 40) begin tick(); n++; end
    check("lp_running", cclk_out[1], 1);
    card_busy[1] = 1'b0;
    highs = 0;
    repeat (22) begin tick(); highs += int'(cclk_out[1]); end
    check("lp_highs", highs, 2);
    repeat (3) tick();
    card_busy[1] = 1'b1;
    n = 0;
    while (!cclk_out[1] && n < 20) begin tick(); n++; end
    check("lp_restart_delay", n, 6);
    hl = 1; n = 0;
    while (n < 20) begin
      tick(); n++;
      if (cclk_out[1]) hl++;
      else break;
    end
    check("lp_restart_high", hl, 4);
    clk_enable[1] = 1'b0; clk_lp_en[1] = 1'b0;

    // Strobe placement and phase clamping table.
    foreach (vecs[v]) begin
      apply_cfg(vecs[v].div, vecs[v].drv, vecs[v].smpl);
      dcnt = 0; scnt = 0; dpos = -1; spos = -1; highs = 0;
      for (int j = 0; j < 2 * vecs[v].div + 2; j++) begin
        tick();
        if (cclk_drv_stb[0]) begin dcnt++; dpos = j; end
        if (cclk_smpl_stb[0]) begin scnt++; spos = j; end
        highs += int'(cclk_out[0]);
      end
      check("tbl_drv_cnt", dcnt, 1);
      check("tbl_drv_pos", dpos, vecs[v].exp_drv);
      check("tbl_smpl_cnt", scnt, 1);
      check("tbl_smpl_pos", spos, vecs[v].exp_smpl);
      check("tbl_high", highs, vecs[v].exp_high);
    end

    // Update landing in the apply cycle: one more apply at the next LAST.
    clk_div = 8'd2; drv_phase = 9'd0; smpl_phase = 9'd1; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    n = 0;
    while (!cfg_ack && n < 100) begin tick(); n++; end
    clk_div = 8'd4; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    n = 1;
    while (!cfg_ack && n < 100) begin tick(); n++; end
    check("coincide_lat", n, 6);

    // Randomised traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      clk_div    = DW'($urandom_range(0, 12));
      drv_phase  = PW'($urandom_range(0, 2 * int'(clk_div) + 4));
      smpl_phase = PW'($urandom_range(0, 2 * int'(clk_div) + 4));
      cfg_update = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) begin
        b = $urandom_range(0, NC - 1);
        case ($urandom_range(0, 2))
          0:       clk_enable[b] = ~clk_enable[b];
          1:       clk_lp_en[b]  = ~clk_lp_en[b];
          default: card_busy[b]  = ~card_busy[b];
        endcase
      end
      tick();
    end
    cfg_update = 1'b0;
    repeat (60) tick();

    // Asynchronous reset in the middle of a div=5 high phase.
    clk_enable = 2'b01; clk_lp_en = '0; card_busy = '0;
    apply_cfg(5, 0, 3);
    n = 0;
    while (!cclk_out[0] && n < 30) begin tick(); n++; end
    repeat (2) tick();
    check("pre_reset_high", cclk_out[0], 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {cfg_ack, clk_ready, cclk_out, cclk_drv_stb, cclk_smpl_stb}, 0);
    repeat (2) @(posedge clk_2x);
    #1;
    check("reset_hold", {cfg_ack, clk_ready, cclk_out, cclk_drv_stb, cclk_smpl_stb}, 0);
    @(negedge clk_2x);
    reset_n = 1'b1;
    model_reset();
    highs = 0;
    for (int k = 1; k <= 402; k++) begin
      tick();
      if (k >= 100 && k < 200) highs += int'(cclk_out[0]);
      if (k == 399) check("rst_ready_early", clk_ready, 0);
      if (k == 400) check("rst_ready_400", clk_ready, 1);
    end
    check("rst_div49_high", highs, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
